fsm10_sched: RTL and testbench
==============================

Name: fsm10_sched

Overview:
- Round-robin scheduler that shares one fsm10 sequencer (10-state S0..S9 machine with go/jmp inputs and Moore output y1) between NREQ requesters.
- For each granted requester it launches exactly one pass of the sequencer, either full (via S1, S2) or short (jump straight to S3). It can hold S3 for a programmable number of extra cycles.
- It tracks the sequencer with a shadow copy of its state, detects the return to S0, and cross-checks y1 against the shadow state.

Parameters:
NREQ, 4, number of requesters (2..8)
HW, 4, width of the per-requester S3 hold count

Ports:
clk  in  1  clock, all flops rise-edge
rst_n  in  1  asynchronous active-low reset
req_i  in  NREQ  request per requester; level, held until its gnt_o bit rises
short_i  in  NREQ  per requester: 1 = launch with jmp (S0->S3), 0 = full pass (S0->S1)
hold_i  in  NREQ*HW  per requester extra S3 cycles; requester r uses bits [r*HW +: HW]
y1_i  in  1  sequencer y1 output
err_clr_i  in  1  single-cycle pulse; clears fault
gnt_o  out  NREQ  one-hot grant, held for the whole pass
done_o  out  NREQ  one-hot single-cycle pulse when the granted pass returns to S0
busy_o  out  1  1 in any state except SC_IDLE
go_o  out  1  sequencer go
jmp_o  out  1  sequencer jmp
err_o  out  1  sticky y1 mismatch flag
shadow_o  out  state_e  shadow sequencer state

Behaviour:
- Reset (async, any time, including mid-pass):
  - Scheduler state SC_IDLE; shadow S0.
  - gnt_o=0, done_o=0, go_o=0, jmp_o=0, busy_o=0, err_o=0.
  - Round-robin pointer = NREQ-1, so requester 0 has top priority first.
- Output timing:
  - go_o and jmp_o decode only from scheduler flops; there is no combinational path from req_i or y1_i.
  - Shadow next state uses the same go/jmp the sequencer samples, with identical transition rules:
    - S0: !go -> S0; go&jmp -> S3; go&!jmp -> S1.
    - S1: jmp -> S3, else S2.
    - S2 -> S3.
    - S3..S8: jmp -> S3, else next state.
    - S9: jmp -> S3, else S0.
- SC_IDLE:
  - If any req_i is set, the winner is the first set bit searching upward from pointer+1 with wrap.
  - Next cycle: SC_LAUNCH, gnt_o=onehot(winner). Latch short and hold of the winner into hold_left. Pointer = winner.
- SC_LAUNCH (1 cycle):
  - go_o=1, jmp_o=latched short. Shadow moves to S1 or S3.
  - Then SC_RUN.
- SC_RUN:
  - go_o=0.
  - jmp_o = (shadow==S3 && hold_left!=0). hold_left decrements on each such cycle.
  - In states other than S3, jmp_o=0.
  - When shadow==S9 and jmp_o=0: next cycle is SC_IDLE with shadow S0, gnt_o=0, done_o=onehot(winner) for that cycle.
  - Arbitration runs in that same done cycle, so the next gnt can rise on the following cycle (1-cycle gap).
- Pass length: gnt_o high for 10+hold cycles (full) or 8+hold cycles (short). done_o comes in the cycle after gnt falls.
- A req_i drop after grant is ignored; the pass always completes.
- A requester re-requesting in its own done cycle loses to any other pending requester.
- Y1 check:
  - Every cycle, y1_i must equal (shadow==S3).
  - On a mismatch in cycle k: err_o=1 and SC_FAULT from cycle k+1. gnt_o=0, go_o=0, jmp_o=0, busy_o=1, no done_o.
- SC_FAULT:
  - Holds until err_clr_i. On the next cycle: err_o=0, shadow S0, SC_IDLE. The pointer is unchanged.
  - The y1 check is suspended while in SC_FAULT.
- err_clr_i outside SC_FAULT has no effect.

Decomposition:
- fsm10_pkg (existing) holds state_e. Add to it:
  - sched_state_e {SC_IDLE, SC_LAUNCH, SC_RUN, SC_FAULT}
  - function fsm10_next(state_e, go, jmp) -> state_e
  - function fsm10_y1(state_e) -> logic
- Sub-module rr_arb: parameter N; inputs req, ptr; outputs onehot grant and index. Purely combinational.
- Scheduler flops live in fsm10_sched.
- The bench instantiates fsm10_sched with a real fsm and connects go/jmp/y1.

Test Plan:
- Full pass: req0=1, short0=0, hold0=0 -> gnt_o=0001 for 10 cycles. go_o=1 only in grant cycle 0; jmp_o never 1; y1 high at grant cycle 3 only; done_o=0001 in cycle 10; shadow_o back at S0; err_o=0.
- Short pass with hold: req1=1, short1=1, hold1=2 -> gnt_o=0010 for 10 cycles. jmp_o=1 in cycles 0,1,2; y1 high in cycles 1-3; shadow S3,S3,S3,S4..S9; done_o=0010 in cycle 10.
- Round robin: req_i=1111 held from reset release, all full hold 0 -> grant order 0,1,2,3,0. Each gnt rises exactly 1 cycle after the previous done_o.
- Re-request priority: in req2's done cycle req_i=0101 -> next gnt_o=0001. Then with req_i=0101 still held -> 0100.
- Fault: force y1_i=0 while shadow==S3 -> err_o=1 and gnt_o=0 next cycle, no done_o. No grant while req held. After an err_clr_i pulse -> err_o=0, and arbitration resumes with the pointer kept.
- Async reset mid-pass (shadow S5, gnt=0100): rst_n low -> all outputs 0 immediately, shadow S0. After release with req_i=1111 -> gnt_o=0001.

Source files
------------

// File: rtl/fsm10_pkg.sv
// Shared types and helpers for the fsm10 sequencer and its round-robin scheduler.
// fsm10_next/fsm10_y1 are the reference transition and output rules for the sequencer.
package fsm10_pkg;

  typedef enum logic [3:0] {
    S0, S1, S2, S3, S4, S5, S6, S7, S8, S9
  } state_e;

  typedef enum logic [1:0] {
    SC_IDLE,
    SC_LAUNCH,
    SC_RUN,
    SC_FAULT
  } sched_state_e;

  function automatic state_e fsm10_next(input state_e s, input logic go, input logic jmp);
    state_e n;
    case (s)
      S0:                     n = go ? (jmp ? S3 : S1) : S0;
      S1:                     n = jmp ? S3 : S2;
      S2:                     n = S3;
      S3, S4, S5, S6, S7, S8: n = jmp ? S3 : state_e'(s + 4'd1);
      S9:                     n = jmp ? S3 : S0;
      default:                n = S0;
    endcase
    return n;
  endfunction

  function automatic logic fsm10_y1(input state_e s);
    return (s == S3);
  endfunction

endpackage

// File: rtl/fsm10.sv
// Ten-state S0..S9 sequencer with go/jmp inputs and Moore output y1 (high in S3).
module fsm10
  import fsm10_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   go_i,
  input  logic   jmp_i,
  output logic   y1_o,
  output state_e state_o
);

  state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S0: if (go_i) state_d = jmp_i ? S3 : S1;
      S1: state_d = jmp_i ? S3 : S2;
      S2: state_d = S3;
      S3: state_d = jmp_i ? S3 : S4;
      S4: state_d = jmp_i ? S3 : S5;
      S5: state_d = jmp_i ? S3 : S6;
      S6: state_d = jmp_i ? S3 : S7;
      S7: state_d = jmp_i ? S3 : S8;
      S8: state_d = jmp_i ? S3 : S9;
      S9: state_d = jmp_i ? S3 : S0;
      default: state_d = S0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  assign y1_o    = (state_q == S3);
  assign state_o = state_q;

endmodule

// File: rtl/rr_arb.sv
// Combinational round-robin arbiter: first set request searching upward from ptr+1 with wrap.
module rr_arb #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = IW'((32'(ptr) + i) % N);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/fsm10_sched.sv
// Round-robin scheduler sharing one fsm10 sequencer; tracks it with a shadow state and
// cross-checks y1 every cycle, parking in SC_FAULT on a mismatch until err_clr_i.
module fsm10_sched
  import fsm10_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned HW   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ-1:0]    short_i,
  input  logic [NREQ*HW-1:0] hold_i,
  input  logic               y1_i,
  input  logic               err_clr_i,
  output logic [NREQ-1:0]    gnt_o,
  output logic [NREQ-1:0]    done_o,
  output logic               busy_o,
  output logic               go_o,
  output logic               jmp_o,
  output logic               err_o,
  output state_e             shadow_o
);

  localparam int unsigned IW = $clog2(NREQ);

  sched_state_e    sc_q, sc_d;
  state_e          shadow_q, shadow_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            short_q, short_d;
  logic [HW-1:0]   hold_left_q, hold_left_d;
  logic            err_q, err_d;

  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            y1_mismatch;

  rr_arb #(
    .N  (NREQ),
    .IW (IW)
  ) u_arb (
    .req (req_i),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // Sequencer controls decode from flops only, so req_i/y1_i never reach go_o/jmp_o.
  always_comb begin
    go_o  = 1'b0;
    jmp_o = 1'b0;
    unique case (sc_q)
      SC_LAUNCH: begin
        go_o  = 1'b1;
        jmp_o = short_q;
      end
      SC_RUN:  jmp_o = (shadow_q == S3) && (hold_left_q != '0);
      default: ;
    endcase
  end

  assign y1_mismatch = (sc_q != SC_FAULT) && (y1_i != fsm10_y1(shadow_q));

  always_comb begin
    sc_d        = sc_q;
    shadow_d    = fsm10_next(shadow_q, go_o, jmp_o);
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    done_d      = '0;
    short_d     = short_q;
    hold_left_d = hold_left_q;
    err_d       = err_q;

    unique case (sc_q)
      SC_IDLE: begin
        if (|req_i) begin
          sc_d        = SC_LAUNCH;
          gnt_d       = arb_gnt;
          ptr_d       = arb_idx;
          short_d     = short_i[arb_idx];
          hold_left_d = hold_i[arb_idx*HW +: HW];
        end
      end
      SC_LAUNCH: sc_d = SC_RUN;
      SC_RUN: begin
        if (jmp_o) begin
          hold_left_d = hold_left_q - HW'(1);
        end else if (shadow_q == S9) begin
          sc_d   = SC_IDLE;
          gnt_d  = '0;
          done_d = gnt_q;
        end
      end
      SC_FAULT: begin
        if (err_clr_i) begin
          sc_d     = SC_IDLE;
          err_d    = 1'b0;
          shadow_d = S0;
        end
      end
      default: sc_d = SC_IDLE;
    endcase

    // A y1 disagreement overrides any grant, launch or completion in this cycle.
    if (y1_mismatch) begin
      sc_d   = SC_FAULT;
      err_d  = 1'b1;
      gnt_d  = '0;
      done_d = '0;
      ptr_d  = ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc_q        <= SC_IDLE;
      shadow_q    <= S0;
      ptr_q       <= IW'(NREQ - 1);
      gnt_q       <= '0;
      done_q      <= '0;
      short_q     <= 1'b0;
      hold_left_q <= '0;
      err_q       <= 1'b0;
    end else begin
      sc_q        <= sc_d;
      shadow_q    <= shadow_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      short_q     <= short_d;
      hold_left_q <= hold_left_d;
      err_q       <= err_d;
    end
  end

  assign gnt_o    = gnt_q;
  assign done_o   = done_q;
  assign busy_o   = (sc_q != SC_IDLE);
  assign err_o    = err_q;
  assign shadow_o = shadow_q;

endmodule

// File: tb/tb_fsm10_sched.sv
// Scoreboard bench for fsm10_sched driving a real fsm10 sequencer.
// Stimulus pushes expected passes; a negedge monitor pops one per grant and checks it.
module tb_fsm10_sched;
  import fsm10_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_i = '0;
  logic [3:0]  short_i = '0;
  logic [15:0] hold_i = '0;
  logic        err_clr_i = 1'b0;
  logic [3:0]  gnt_o, done_o;
  logic        busy_o, go_o, jmp_o, err_o;
  state_e      shadow_o, seq_state;
  logic        y1_seq, y1_kill = 1'b0;
  logic        y1_i;

  int checks = 0;
  int failures = 0;

  assign y1_i = y1_seq & ~y1_kill;

  always #5 clk = ~clk;

  fsm10_sched #(.NREQ(4), .HW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_i),
    .short_i   (short_i),
    .hold_i    (hold_i),
    .y1_i      (y1_i),
    .err_clr_i (err_clr_i),
    .gnt_o     (gnt_o),
    .done_o    (done_o),
    .busy_o    (busy_o),
    .go_o      (go_o),
    .jmp_o     (jmp_o),
    .err_o     (err_o),
    .shadow_o  (shadow_o)
  );

  fsm10 u_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .go_i    (go_o),
    .jmp_i   (jmp_o),
    .y1_o    (y1_seq),
    .state_o (seq_state)
  );

  typedef struct {
    logic [3:0]  gnt;
    int          len;
    logic [15:0] go_m;
    logic [15:0] jmp_m;
    logic [15:0] y1_m;
    logic [63:0] sh;
    bit          gap1;
    bit          abort;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Full pass, hold 0: S0..S9, go in cycle 0, y1 in cycle 3.
  function automatic exp_t mk_full(input logic [3:0] g, input bit gap);
    exp_t e;
    e.gnt = g; e.len = 10; e.go_m = 16'h0001; e.jmp_m = 16'h0000; e.y1_m = 16'h0008;
    e.sh = 64'h0000_0098_7654_3210; e.gap1 = gap; e.abort = 1'b0;
    return e;
  endfunction

  // Short pass, hold 2: S0,S3,S3,S3,S4..S9; jmp in cycles 0-2, y1 in cycles 1-3.
  function automatic exp_t mk_short_h2(input logic [3:0] g, input bit gap);
    exp_t e;
    e.gnt = g; e.len = 10; e.go_m = 16'h0001; e.jmp_m = 16'h0007; e.y1_m = 16'h000E;
    e.sh = 64'h0000_0098_7654_3330; e.gap1 = gap; e.abort = 1'b0;
    return e;
  endfunction

  function automatic exp_t mk_abort(input logic [3:0] g, input int n);
    exp_t e;
    e.gnt = g; e.len = n; e.go_m = '0; e.jmp_m = '0; e.y1_m = '0;
    e.sh = '0; e.gap1 = 1'b0; e.abort = 1'b1;
    return e;
  endfunction

  // Monitor: one expected item per grant rising edge, checked when the grant ends.
  exp_t        cur;
  bit          in_pass = 0;
  bit          gnt_changed;
  int          cyc = 0;
  int          last_done = -100;
  int          len;
  int          track_err = 0;
  logic [15:0] go_t, jmp_t, y1_t;
  logic [63:0] sh_t;

  always @(negedge clk) begin
    cyc++;
    if (shadow_o != seq_state) track_err++;
    if (!in_pass && gnt_o != '0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_gnt", 64'(gnt_o), 64'h0);
      end else begin
        cur = exp_q.pop_front();
        in_pass = 1; len = 0; gnt_changed = 0;
        go_t = '0; jmp_t = '0; y1_t = '0; sh_t = '0;
        chk("gnt_value", 64'(gnt_o), 64'(cur.gnt));
        if (cur.gap1) chk("gnt_gap_after_done", 64'(cyc - last_done), 64'd1);
      end
    end
    if (in_pass) begin
      if (gnt_o != '0) begin
        if (gnt_o != cur.gnt) gnt_changed = 1;
        if (len < 16) begin
          go_t[len] = go_o; jmp_t[len] = jmp_o; y1_t[len] = y1_seq;
          sh_t[len*4 +: 4] = shadow_o;
        end
        len++;
      end else begin
        in_pass = 0;
        chk("gnt_held", 64'(gnt_changed), 64'h0);
        chk("pass_len", 64'(len), 64'(cur.len));
        if (done_o != '0) begin
          last_done = cyc;
          chk("pass_completed_expected", 64'(cur.abort), 64'h0);
          chk("done_value", 64'(done_o), 64'(cur.gnt));
          chk("go_trace", 64'(go_t), 64'(cur.go_m));
          chk("jmp_trace", 64'(jmp_t), 64'(cur.jmp_m));
          chk("y1_trace", 64'(y1_t), 64'(cur.y1_m));
          chk("shadow_trace", sh_t, cur.sh);
          chk("shadow_at_done", 64'(shadow_o), 64'(S0));
          chk("err_at_done", 64'(err_o), 64'h0);
        end else begin
          chk("pass_aborted_expected", 64'(cur.abort), 64'h1);
        end
      end
    end
  end

  task automatic wait_gnt(input logic [3:0] m, input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt_o != m && n < 200);
    if (gnt_o != m) chk({"timeout_gnt_", nm}, 64'(gnt_o), 64'(m));
  endtask

  task automatic wait_done(input logic [3:0] m, input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done_o != m && n < 200);
    if (done_o != m) chk({"timeout_done_", nm}, 64'(done_o), 64'(m));
  endtask

  task automatic wait_shadow(input state_e s, input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (shadow_o != s && n < 200);
    if (shadow_o != s) chk({"timeout_shadow_", nm}, 64'(shadow_o), 64'(s));
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_gnt"}, 64'(gnt_o), 64'h0);
    chk({nm, "_done"}, 64'(done_o), 64'h0);
    chk({nm, "_go"}, 64'(go_o), 64'h0);
    chk({nm, "_jmp"}, 64'(jmp_o), 64'h0);
    chk({nm, "_busy"}, 64'(busy_o), 64'h0);
    chk({nm, "_err"}, 64'(err_o), 64'h0);
    chk({nm, "_shadow"}, 64'(shadow_o), 64'(S0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] gnt_seen;
    logic [3:0] done_seen;

    // Reset state
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full pass on requester 0
    exp_q.push_back(mk_full(4'b0001, 0));
    req_i = 4'b0001;
    wait_gnt(4'b0001, "full0");
    req_i = '0;
    wait_done(4'b0001, "full0");
    repeat (3) @(negedge clk);

    // Short pass with hold 2 on requester 1
    exp_q.push_back(mk_short_h2(4'b0010, 0));
    short_i = 4'b0010;
    hold_i  = 16'h0020;
    req_i   = 4'b0010;
    wait_gnt(4'b0010, "short1");
    req_i = '0;
    wait_done(4'b0010, "short1");
    short_i = '0;
    hold_i  = '0;
    repeat (3) @(negedge clk);

    // Round robin from reset release with all requests held
    rst_n = 1'b0;
    @(negedge clk);
    req_i = 4'b1111;
    exp_q.push_back(mk_full(4'b0001, 0));
    exp_q.push_back(mk_full(4'b0010, 1));
    exp_q.push_back(mk_full(4'b0100, 1));
    exp_q.push_back(mk_full(4'b1000, 1));
    exp_q.push_back(mk_full(4'b0001, 1));
    @(negedge clk);
    rst_n = 1'b1;
    wait_gnt(4'b1000, "rr3");
    wait_gnt(4'b0001, "rr0b");
    req_i = '0;
    wait_done(4'b0001, "rr0b");
    repeat (3) @(negedge clk);

    // Re-request in own done cycle loses to another pending requester
    exp_q.push_back(mk_full(4'b0100, 0));
    exp_q.push_back(mk_full(4'b0001, 1));
    exp_q.push_back(mk_full(4'b0100, 1));
    req_i = 4'b0100;
    wait_done(4'b0100, "rereq2");
    req_i = 4'b0101;
    wait_gnt(4'b0001, "rereq0");
    wait_gnt(4'b0100, "rereq2b");
    req_i = '0;
    wait_done(4'b0100, "rereq2b");
    repeat (3) @(negedge clk);

    // y1 fault while shadow is in S3
    exp_q.push_back(mk_abort(4'b0001, 4));
    req_i = 4'b0001;
    wait_gnt(4'b0001, "fault0");
    wait_shadow(S3, "fault_s3");
    y1_kill = 1'b1;
    @(negedge clk);
    y1_kill = 1'b0;
    chk("fault_err", 64'(err_o), 64'h1);
    chk("fault_gnt", 64'(gnt_o), 64'h0);
    chk("fault_busy", 64'(busy_o), 64'h1);
    chk("fault_go_jmp", {62'h0, go_o, jmp_o}, 64'h0);
    req_i = 4'b0011;
    gnt_seen = '0;
    done_seen = '0;
    repeat (20) begin
      @(negedge clk);
      gnt_seen |= gnt_o;
      done_seen |= done_o;
    end
    chk("no_gnt_in_fault", 64'(gnt_seen), 64'h0);
    chk("no_done_in_fault", 64'(done_seen), 64'h0);
    chk("err_sticky", 64'(err_o), 64'h1);
    exp_q.push_back(mk_full(4'b0010, 0));
    err_clr_i = 1'b1;
    @(negedge clk);
    err_clr_i = 1'b0;
    chk("clr_err", 64'(err_o), 64'h0);
    chk("clr_busy", 64'(busy_o), 64'h0);
    chk("clr_shadow", 64'(shadow_o), 64'(S0));
    wait_gnt(4'b0010, "after_clr");
    req_i = '0;
    wait_done(4'b0010, "after_clr");
    repeat (3) @(negedge clk);

    // Asynchronous reset mid-pass
    exp_q.push_back(mk_abort(4'b0100, 6));
    req_i = 4'b0100;
    wait_gnt(4'b0100, "rst_pass");
    req_i = '0;
    wait_shadow(S5, "rst_s5");
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    exp_q.push_back(mk_full(4'b0001, 0));
    req_i = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_gnt(4'b0001, "post_rst");
    req_i = '0;
    wait_done(4'b0001, "post_rst");
    repeat (3) @(negedge clk);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    chk("monitor_idle", 64'(in_pass), 64'h0);
    chk("shadow_tracks_sequencer", 64'(track_err), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
